uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, majority-voted bit recovery feeding a
// valid/ready output register with per-word parity/frame flags and sticky overrun.
module uart_rx_param #(
   parameter int CLK_FREQ   = 1_536_000,
   parameter int BAUD_RATE  = 9_600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 1,
   parameter int STOP_BITS  = 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 RXD,
   output logic [DATA_BITS-1:0] RX_DATA,
   output logic                 RX_VALID,
   input  logic                 RX_READY,
   output logic                 PARITY_ERR,
   output logic                 FRAME_ERR,
   output logic                 OVERRUN,
   output logic                 BUSY
);
   localparam int   DIV       = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int   TW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int   SW        = $clog2(OVERSAMPLE);
   localparam int   BW        = $clog2(DATA_BITS);
   localparam int   M         = OVERSAMPLE / 2;
   localparam logic ODD_PAR   = (PARITY == 2) ? 1'b1 : 1'b0;
   localparam logic USE_PAR   = (PARITY != 0) ? 1'b1 : 1'b0;
   localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   function automatic logic maj3_f(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

   logic                 rx_meta_q, rxs_q;
   logic [TW-1:0]        tick_cnt_q;
   logic [SW-1:0]        samp_q;
   logic [1:0]           smp_q;
   state_t               state_q;
   logic [BW-1:0]        bit_q;
   logic                 stop_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_err_q, ferr_lat_q, busy_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q, perr_out_q, ferr_out_q, ovr_q;

   logic tick_s, start_s, mid_end_s, bit_end_s, vote_s, complete_s, accept_s;

   assign tick_s     = (tick_cnt_q == TW'(DIV - 1));
   assign start_s    = (state_q == S_IDLE) && !rxs_q;
   assign mid_end_s  = tick_s && (samp_q == SW'(M + 1));
   assign bit_end_s  = tick_s && (samp_q == SW'(OVERSAMPLE - 1));
   assign vote_s     = maj3_f(smp_q[0], smp_q[1], rxs_q);
   assign complete_s = (state_q == S_STOP) && mid_end_s && (stop_q == LAST_STOP);
   assign accept_s   = valid_q && RX_READY;

   // Two-flop synchroniser for the asynchronous line, idling high
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= RXD;
         rxs_q     <= rx_meta_q;
      end
   end

   // Oversample tick divider, sample-slot counter and the two early vote samples
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick_cnt_q <= {TW{1'b0}};
         samp_q     <= {SW{1'b0}};
         smp_q      <= 2'b00;
      end else if (start_s) begin
         tick_cnt_q <= {TW{1'b0}};
         samp_q     <= {SW{1'b0}};
      end else if (tick_s) begin
         tick_cnt_q <= {TW{1'b0}};
         samp_q     <= (samp_q == SW'(OVERSAMPLE - 1)) ? {SW{1'b0}} : samp_q + 1'b1;
         if (samp_q == SW'(M - 1)) begin
            smp_q[0] <= rxs_q;
         end else if (samp_q == SW'(M)) begin
            smp_q[1] <= rxs_q;
         end else begin
            smp_q <= smp_q;
         end
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   // Frame state machine plus the valid/ready output register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         bit_q      <= {BW{1'b0}};
         stop_q     <= 1'b0;
         shift_q    <= {DATA_BITS{1'b0}};
         par_err_q  <= 1'b0;
         ferr_lat_q <= 1'b0;
         busy_q     <= 1'b0;
         data_q     <= {DATA_BITS{1'b0}};
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!rxs_q) begin
                  state_q    <= S_START;
                  busy_q     <= 1'b1;
                  bit_q      <= {BW{1'b0}};
                  stop_q     <= 1'b0;
                  par_err_q  <= 1'b0;
                  ferr_lat_q <= 1'b0;
               end
            end
            S_START: begin
               if (mid_end_s && vote_s) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (bit_end_s) begin
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (mid_end_s) begin
                  shift_q <= {vote_s, shift_q[DATA_BITS-1:1]};
               end
               if (bit_end_s) begin
                  if (bit_q == BW'(DATA_BITS - 1)) begin
                     bit_q   <= {BW{1'b0}};
                     state_q <= USE_PAR ? S_PARITY : S_STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (mid_end_s) begin
                  par_err_q <= vote_s ^ parity_f(shift_q) ^ ODD_PAR;
               end
               if (bit_end_s) begin
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               // Completion is at mid-bit so the next start edge is never missed
               if (mid_end_s) begin
                  if (!vote_s) begin
                     ferr_lat_q <= 1'b1;
                  end
                  if (stop_q == LAST_STOP) begin
                     state_q <= vote_s ? S_IDLE : S_WAIT_HIGH;
                     busy_q  <= !vote_s;
                  end else begin
                     stop_q <= stop_q + 1'b1;
                  end
               end
            end
            S_WAIT_HIGH: begin
               if (rxs_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase

         if (complete_s && (!valid_q || accept_s)) begin
            data_q     <= shift_q;
            perr_out_q <= par_err_q;
            ferr_out_q <= ferr_lat_q | ~vote_s;
            valid_q    <= 1'b1;
            if (accept_s) begin
               ovr_q <= 1'b0;
            end
         end else if (complete_s) begin
            ovr_q <= 1'b1;
         end else if (accept_s) begin
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
         end
      end
   end

   assign RX_DATA    = data_q;
   assign RX_VALID   = valid_q;
   assign PARITY_ERR = perr_out_q;
   assign FRAME_ERR  = ferr_out_q;
   assign OVERRUN    = ovr_q;
   assign BUSY       = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8E1, 8O1, 7N2) driven
// from a vector table plus hand-written sequences for error, glitch, overrun, reset.
module tb_uart_rx_param;
   localparam int BIT = 160;

   typedef struct {
      int          dut;
      logic [15:0] line;
      int          nbits;
      logic [8:0]  exp_data;
      logic        exp_perr;
      logic        exp_ferr;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] rxd, rdy;
   logic [2:0] val, perr, ferr, ovr, busy;
   logic [7:0] dat0, dat1;
   logic [6:0] dat2;
   logic [8:0] datx [3];

   int checks = 0;
   int errors = 0;
   int vcnt [3] = '{0, 0, 0};
   logic       prev [3] = '{1'b0, 1'b0, 1'b0};
   logic [8:0] cap_data [3];
   logic       cap_perr [3];
   logic       cap_ferr [3];
   logic       cap_busy [3];

   uart_rx_param u_8e1 (
      .CLK(clk), .RST_N(rst_n), .RXD(rxd[0]), .RX_DATA(dat0), .RX_VALID(val[0]),
      .RX_READY(rdy[0]), .PARITY_ERR(perr[0]), .FRAME_ERR(ferr[0]),
      .OVERRUN(ovr[0]), .BUSY(busy[0]));

   uart_rx_param #(.PARITY(2)) u_8o1 (
      .CLK(clk), .RST_N(rst_n), .RXD(rxd[1]), .RX_DATA(dat1), .RX_VALID(val[1]),
      .RX_READY(rdy[1]), .PARITY_ERR(perr[1]), .FRAME_ERR(ferr[1]),
      .OVERRUN(ovr[1]), .BUSY(busy[1]));

   uart_rx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
      .CLK(clk), .RST_N(rst_n), .RXD(rxd[2]), .RX_DATA(dat2), .RX_VALID(val[2]),
      .RX_READY(rdy[2]), .PARITY_ERR(perr[2]), .FRAME_ERR(ferr[2]),
      .OVERRUN(ovr[2]), .BUSY(busy[2]));

   assign datx[0] = {1'b0, dat0};
   assign datx[1] = {1'b0, dat1};
   assign datx[2] = {2'b00, dat2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record each RX_VALID rising edge and the word presented with it
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         prev[k] <= val[k];
         if (val[k] && !prev[k]) begin
            vcnt[k]     <= vcnt[k] + 1;
            cap_data[k] <= datx[k];
            cap_perr[k] <= perr[k];
            cap_ferr[k] <= ferr[k];
            cap_busy[k] <= busy[k];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_line(input int k, input logic [15:0] line, input int n);
      for (int i = 0; i < n; i++) begin
         rxd[k] = line[i];
         idle(BIT);
      end
   endtask

   function automatic logic [15:0] f8(input logic [7:0] d, input logic p, input logic s);
      return {5'b00000, s, p, d, 1'b0};
   endfunction

   function automatic logic [15:0] f7(input logic [6:0] d);
      return {6'b000000, 2'b11, d, 1'b0};
   endfunction

   vec_t vecs [7];
   int   c0;
   int   k;
   logic seen;

   initial begin
      vecs[0] = '{0, f8(8'h41, 1'b0, 1'b1), 11, 9'h041, 1'b0, 1'b0};
      vecs[1] = '{0, f8(8'h41, 1'b1, 1'b1), 11, 9'h041, 1'b1, 1'b0};
      vecs[2] = '{0, f8(8'h55, 1'b0, 1'b1), 11, 9'h055, 1'b0, 1'b0};
      vecs[3] = '{0, f8(8'h80, 1'b1, 1'b1), 11, 9'h080, 1'b0, 1'b0};
      vecs[4] = '{1, f8(8'h41, 1'b1, 1'b1), 11, 9'h041, 1'b0, 1'b0};
      vecs[5] = '{1, f8(8'h41, 1'b0, 1'b1), 11, 9'h041, 1'b1, 1'b0};
      vecs[6] = '{2, f7(7'h2A),             10, 9'h02A, 1'b0, 1'b0};

      rst_n = 1'b0;
      rxd   = 3'b111;
      rdy   = 3'b111;
      idle(5);
      chk("reset_8e1", 32'({dat0, val[0], perr[0], ferr[0], ovr[0], busy[0]}), 32'd0);
      chk("reset_8o1", 32'({dat1, val[1], perr[1], ferr[1], ovr[1], busy[1]}), 32'd0);
      chk("reset_7n2", 32'({dat2, val[2], perr[2], ferr[2], ovr[2], busy[2]}), 32'd0);
      rst_n = 1'b1;
      idle(BIT);

      for (int i = 0; i < 7; i++) begin
         k  = vecs[i].dut;
         c0 = vcnt[k];
         send_line(k, vecs[i].line, vecs[i].nbits);
         rxd[k] = 1'b1;
         idle(200);
         chk($sformatf("v%0d_count", i), 32'(vcnt[k] - c0), 32'd1);
         chk($sformatf("v%0d_data", i), 32'(cap_data[k]), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d_perr", i), 32'(cap_perr[k]), 32'(vecs[i].exp_perr));
         chk($sformatf("v%0d_ferr", i), 32'(cap_ferr[k]), 32'(vecs[i].exp_ferr));
         chk($sformatf("v%0d_busy_at_valid", i), 32'(cap_busy[k]), 32'd0);
      end

      // Stop bit 0 followed by a three-bit break: one word, then wait for high
      c0 = vcnt[0];
      send_line(0, f8(8'h41, 1'b0, 1'b0), 11);
      idle(3 * BIT);
      chk("brk_busy_low_line", 32'(busy[0]), 32'd1);
      chk("brk_count_low", 32'(vcnt[0] - c0), 32'd1);
      rxd[0] = 1'b1;
      idle(200);
      chk("brk_count", 32'(vcnt[0] - c0), 32'd1);
      chk("brk_data", 32'(cap_data[0]), 32'h041);
      chk("brk_ferr", 32'(cap_ferr[0]), 32'd1);
      chk("brk_perr", 32'(cap_perr[0]), 32'd0);
      chk("brk_idle_after_high", 32'(busy[0]), 32'd0);

      // Short low glitch is rejected at the start-bit vote
      c0     = vcnt[0];
      seen   = 1'b0;
      rxd[0] = 1'b0;
      idle(40);
      rxd[0] = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         seen = seen | busy[0];
      end
      chk("glitch_busy_seen", 32'(seen), 32'd1);
      chk("glitch_no_valid", 32'(vcnt[0] - c0), 32'd0);
      chk("glitch_busy_clear", 32'(busy[0]), 32'd0);
      send_line(0, f8(8'h55, 1'b0, 1'b1), 11);
      idle(200);
      chk("glitch_next_count", 32'(vcnt[0] - c0), 32'd1);
      chk("glitch_next_data", 32'(cap_data[0]), 32'h055);

      // Consumer stalled: second word dropped, overrun sticky until accept
      rdy[0] = 1'b0;
      c0     = vcnt[0];
      send_line(0, f8(8'h41, 1'b0, 1'b1), 11);
      idle(200);
      send_line(0, f8(8'h7E, 1'b0, 1'b1), 11);
      idle(200);
      chk("ovr_count", 32'(vcnt[0] - c0), 32'd1);
      chk("ovr_data_held", 32'(dat0), 32'h41);
      chk("ovr_valid_held", 32'(val[0]), 32'd1);
      chk("ovr_flag", 32'(ovr[0]), 32'd1);
      rdy[0] = 1'b1;
      @(negedge clk);
      rdy[0] = 1'b0;
      chk("ovr_accept_valid", 32'(val[0]), 32'd0);
      chk("ovr_accept_clear", 32'(ovr[0]), 32'd0);
      rdy[0] = 1'b1;
      idle(20);

      // Reset during data bit 3 of a 7N2 frame
      c0 = vcnt[2];
      send_line(2, f7(7'h2A), 4);
      rxd[2] = 1'b1;
      idle(BIT / 2);
      chk("mid_busy_before_rst", 32'(busy[2]), 32'd1);
      rst_n  = 1'b0;
      @(negedge clk);
      chk("mid_rst_outs", 32'({dat2, val[2], perr[2], ferr[2], ovr[2], busy[2]}), 32'd0);
      idle(10);
      rst_n = 1'b1;
      idle(2000);
      chk("mid_rst_no_valid", 32'(vcnt[2] - c0), 32'd0);
      chk("mid_rst_idle", 32'({val[2], busy[2]}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
